shift_sequencer: RTL and testbench

- Multicycle execute-stage sequencer for all RV64I shift instructions: SLL/SRL/SRA, SLLI/SRLI/SRAI, SLLW/SRLW/SRAW, SLLIW/SRLIW/SRAIW.
- Sits directly upstream of the 64-bit combinational shifter. It latches operands from decode/register read and drives the shifter's data, amount and mode inputs.
- It captures the shifter output and applies word-variant truncation, sign extension and arithmetic sign fill.
- It returns the result to writeback over a valid/ready handshake.

---
 rtl/shift_sequencer.sv | 141 ++++++++++++++
 tb/tb_shift_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Sequences RV64I shifts around an external combinational shifter; fixes up word/arith results.
// Latency: result valid on the second edge after acceptance (IDLE -> SHIFT -> DONE).
// Backpressure: result held in DONE until res_ready; op_ready only in IDLE (no overlap).
module shift_sequencer #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [DATA_W-1:0]  rs1_data,
    input  logic [DATA_W-1:0]  rs2_data,
    input  logic [SHAMT_W-1:0] imm_shamt,
    input  logic [2:0]         funct3,
    input  logic               funct7_b30,
    input  logic               is_imm,
    input  logic               is_word,
    output logic [DATA_W-1:0]  sh_in,
    output logic [SHAMT_W-1:0] sh_n,
    output logic [1:0]         sh_shift,
    input  logic [DATA_W-1:0]  sh_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_illegal
);

    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  in_q, res_q;
    logic [SHAMT_W-1:0] n_q;
    logic [1:0]         mode_q;
    logic               word_q, ill_q, res_ill_q;

    logic [SHAMT_W-1:0] amt, dec_n;
    logic [1:0]         dec_mode;
    logic               dec_ill;
    logic [DATA_W-1:0]  dec_in;
    logic [DATA_W-1:0]  fill, filled, post;
    logic               accept;

    // Only the low shift-amount bits of rs2 matter; the rest are deliberately dropped.
    logic unused_rs2;
    assign unused_rs2 = ^rs2_data[DATA_W-1:SHAMT_W];

    assign accept = (state == IDLE) && op_valid && !flush;

    // Decode the presented operation into shifter mode, amount, data and legality.
    always_comb begin
        amt      = is_imm ? imm_shamt : rs2_data[SHAMT_W-1:0];
        dec_n    = is_word ? {1'b0, amt[SHAMT_W-2:0]} : amt;
        dec_ill  = 1'b0;
        dec_mode = 2'b11;
        case (funct3)
            3'b001: begin
                if (funct7_b30) dec_ill  = 1'b1;
                else            dec_mode = 2'b00;
            end
            3'b101:  dec_mode = funct7_b30 ? 2'b10 : 2'b01;
            default: dec_ill  = 1'b1;
        endcase
        // A W immediate with shamt[5] set is reserved; a register amount just drops bit 5.
        if (is_word && is_imm && imm_shamt[SHAMT_W-1]) dec_ill = 1'b1;
        // Illegal ops keep the shifter in pass-through for the whole operation.
        if (dec_ill) dec_mode = 2'b11;
        dec_in = rs1_data;
        if (is_word && dec_mode == 2'b01) dec_in = {{HALF{1'b0}}, rs1_data[HALF-1:0]};
        if (is_word && dec_mode == 2'b10) dec_in = {{HALF{rs1_data[HALF-1]}}, rs1_data[HALF-1:0]};
    end

    // Post-process the shifter output: own sign fill (shifter may fill logically), word sext.
    always_comb begin
        fill   = (mode_q == 2'b10 && in_q[DATA_W-1]) ? ~({DATA_W{1'b1}} >> n_q) : '0;
        filled = sh_out | fill;
        if (ill_q)       post = '0;
        else if (word_q) post = {{HALF{filled[HALF-1]}}, filled[HALF-1:0]};
        else             post = filled;
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_valid) state_nxt = SHIFT;
            SHIFT:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Operand registers, loaded only at acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= '0;
            n_q    <= '0;
            mode_q <= 2'b00;
            word_q <= 1'b0;
            ill_q  <= 1'b0;
        end else if (accept) begin
            in_q   <= dec_in;
            n_q    <= dec_n;
            mode_q <= dec_mode;
            word_q <= is_word;
            ill_q  <= dec_ill;
        end
    end

    // Result capture at the end of SHIFT; flush clears the illegal flag but keeps the data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q     <= '0;
            res_ill_q <= 1'b0;
        end else if (flush) begin
            res_ill_q <= 1'b0;
        end else if (state == SHIFT) begin
            res_q     <= post;
            res_ill_q <= ill_q;
        end
    end

    assign op_ready    = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign sh_shift    = (state == SHIFT) ? mode_q : 2'b11;
    assign sh_in       = in_q;
    assign sh_n        = n_q;
    assign res_data    = res_q;
    assign res_illegal = res_ill_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a logical-fill shifter model.
// Latency: checks SHIFT one edge and DONE two edges after acceptance.
// Backpressure: holds res_ready low in DONE and checks the result stays put.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic [5:0]  imm_shamt = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_b30 = 1'b0;
    logic        is_imm = 1'b0;
    logic        is_word = 1'b0;
    logic [63:0] sh_in;
    logic [5:0]  sh_n;
    logic [1:0]  sh_shift;
    logic [63:0] sh_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shifter model: mode 10 deliberately fills with zeros so the DUT must supply the sign.
    always_comb begin
        case (sh_shift)
            2'b00:   sh_out = sh_in << sh_n;
            2'b01:   sh_out = sh_in >> sh_n;
            2'b10:   sh_out = sh_in >> sh_n;
            default: sh_out = sh_in;
        endcase
    end

    shift_sequencer dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .op_valid(op_valid), .op_ready(op_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_shamt(imm_shamt),
        .funct3(funct3), .funct7_b30(funct7_b30), .is_imm(is_imm), .is_word(is_word),
        .sh_in(sh_in), .sh_n(sh_n), .sh_shift(sh_shift), .sh_out(sh_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_illegal(res_illegal)
    );

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [5:0]  imm;
        logic [2:0]  f3;
        logic        b30;
        logic        is_imm;
        logic        is_word;
        logic [1:0]  mode;
        logic [5:0]  n;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        rs1_data   = vt[i].rs1;
        rs2_data   = vt[i].rs2;
        imm_shamt  = vt[i].imm;
        funct3     = vt[i].f3;
        funct7_b30 = vt[i].b30;
        is_imm     = vt[i].is_imm;
        is_word    = vt[i].is_word;
    endtask

    // Accept vector i; return one step past the acceptance edge, DUT in SHIFT.
    task automatic accept_op(input int i);
        @(negedge clk);
        drive(i);
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        // Scramble inputs: they must not matter after acceptance.
        rs1_data  = ~vt[i].rs1;
        rs2_data  = ~vt[i].rs2;
        imm_shamt = ~vt[i].imm;
        funct3    = 3'b111;
    endtask

    task automatic run_vec(input int i);
        accept_op(i);
        chk($sformatf("v%0d shift_mode", i), 64'(sh_shift), 64'(vt[i].mode));
        chk($sformatf("v%0d op_ready_busy", i), 64'(op_ready), 64'd0);
        if (!vt[i].ill) chk($sformatf("v%0d sh_n", i), 64'(sh_n), 64'(vt[i].n));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d res_valid", i), 64'(res_valid), 64'd1);
        chk($sformatf("v%0d res_data", i), res_data, vt[i].exp);
        chk($sformatf("v%0d res_illegal", i), 64'(res_illegal), 64'(vt[i].ill));
        chk($sformatf("v%0d done_mode", i), 64'(sh_shift), 64'd3);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk($sformatf("v%0d back_idle", i), 64'(op_ready), 64'd1);
        chk($sformatf("v%0d valid_drop", i), 64'(res_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            rs1                     rs2      imm  f3     b30 imm word mode  n   exp                   ill
        vt[0]  = '{64'h1,                 64'h0,   6'd4,  3'b001, 0, 1, 0, 2'b00, 6'd4,  64'h10,                0};
        vt[1]  = '{64'h8000_0000_0000_0000, 64'h43, 6'd0,  3'b101, 1, 0, 0, 2'b10, 6'd3,  64'hF000_0000_0000_0000, 0};
        vt[2]  = '{64'h0000_0000_8000_0000, 64'h4,  6'd0,  3'b101, 1, 0, 1, 2'b10, 6'd4,  64'hFFFF_FFFF_F800_0000, 0};
        vt[3]  = '{64'h0000_0000_8000_0000, 64'h4,  6'd0,  3'b101, 0, 0, 1, 2'b01, 6'd4,  64'h0000_0000_0800_0000, 0};
        vt[4]  = '{64'h1,                 64'd31,  6'd0,  3'b001, 0, 0, 1, 2'b00, 6'd31, 64'hFFFF_FFFF_8000_0000, 0};
        vt[5]  = '{64'h1,                 64'h21,  6'd0,  3'b001, 0, 0, 1, 2'b00, 6'd1,  64'h2,                 0};
        vt[6]  = '{64'h1234,              64'h0,   6'd32, 3'b001, 0, 1, 1, 2'b11, 6'd0,  64'h0,                 1};
        vt[7]  = '{64'h1234,              64'h5,   6'd0,  3'b011, 0, 0, 0, 2'b11, 6'd5,  64'h0,                 1};
        vt[8]  = '{64'h1234,              64'h2,   6'd0,  3'b001, 1, 0, 0, 2'b11, 6'd2,  64'h0,                 1};
        vt[9]  = '{64'h1234_5678_9ABC_DEF0, 64'h40, 6'd0,  3'b101, 0, 0, 0, 2'b01, 6'd0,  64'h1234_5678_9ABC_DEF0, 0};
        vt[10] = '{64'h8000_0000_0000_0001, 64'h0,  6'd63, 3'b101, 1, 1, 0, 2'b10, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vt[11] = '{64'h0000_0000_8000_0001, 64'h0,  6'd0,  3'b101, 0, 1, 1, 2'b01, 6'd0,  64'hFFFF_FFFF_8000_0001, 0};
        vt[12] = '{64'h4000_0000_0000_0000, 64'h2,  6'd0,  3'b101, 1, 0, 0, 2'b10, 6'd2,  64'h1000_0000_0000_0000, 0};
        vt[13] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,  6'd60, 3'b101, 0, 1, 0, 2'b01, 6'd60, 64'hF,                 0};
        vt[14] = '{64'h8000_0000,          64'h0,  6'd33, 3'b101, 1, 1, 1, 2'b11, 6'd1,  64'h0,                 1};
        vt[15] = '{64'h7000_0000,          64'h3C, 6'd0,  3'b101, 1, 0, 1, 2'b10, 6'd28, 64'h7,                 0};
        vt[16] = '{64'h1,                 64'd63,  6'd0,  3'b001, 0, 0, 0, 2'b00, 6'd63, 64'h8000_0000_0000_0000, 0};

        // Reset state.
        #12;
        chk("rst op_ready", 64'(op_ready), 64'd1);
        chk("rst res_valid", 64'(res_valid), 64'd0);
        chk("rst res_data", res_data, 64'd0);
        chk("rst res_illegal", 64'(res_illegal), 64'd0);
        chk("rst sh_shift", 64'(sh_shift), 64'd3);
        chk("rst sh_in", sh_in, 64'd0);
        chk("rst sh_n", 64'(sh_n), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset in the middle of SHIFT.
        accept_op(1);
        chk("pre-rst shift_mode", 64'(sh_shift), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst res_valid", 64'(res_valid), 64'd0);
        chk("midrst op_ready", 64'(op_ready), 64'd1);
        chk("midrst sh_shift", 64'(sh_shift), 64'd3);
        chk("midrst sh_in", sh_in, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven vectors; vt[0] is the SLLI right after reset.
        for (int i = 0; i < 17; i++) run_vec(i);

        // Back-pressure: stay in DONE for 5 cycles while inputs wiggle.
        accept_op(2);
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            op_valid = ~op_valid;
            rs1_data = rs1_data + 64'h1111;
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d res_valid", c), 64'(res_valid), 64'd1);
            chk($sformatf("bp%0d res_data", c), res_data, 64'hFFFF_FFFF_F800_0000);
            chk($sformatf("bp%0d op_ready", c), 64'(op_ready), 64'd0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("bp release idle", 64'(op_ready), 64'd1);
        chk("bp release valid", 64'(res_valid), 64'd0);

        // Flush during SHIFT: no result appears, previous data retained.
        accept_op(13);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flsh_shift idle", 64'(op_ready), 64'd1);
        chk("flsh_shift valid", 64'(res_valid), 64'd0);
        chk("flsh_shift data kept", res_data, 64'hFFFF_FFFF_F800_0000);
        @(posedge clk);
        #1;
        chk("flsh_shift no result", 64'(res_valid), 64'd0);

        // Flush during DONE with res_ready high: illegal flag cleared, data kept.
        accept_op(7);
        @(posedge clk);
        #1;
        chk("flsh_done pre illegal", 64'(res_illegal), 64'd1);
        flush     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        res_ready = 1'b0;
        chk("flsh_done idle", 64'(op_ready), 64'd1);
        chk("flsh_done valid", 64'(res_valid), 64'd0);
        chk("flsh_done illegal", 64'(res_illegal), 64'd0);
        chk("flsh_done data kept", res_data, 64'd0);

        // Flush beats op_valid in IDLE: nothing accepted.
        @(negedge clk);
        drive(0);
        op_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        chk("flsh_idle op_ready", 64'(op_ready), 64'd1);
        chk("flsh_idle sh_shift", 64'(sh_shift), 64'd3);
        @(posedge clk);
        #1;
        chk("flsh_idle no result", 64'(res_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
